// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU control decoder
// Contents: alu_op_e encoding, RV32I opcode/funct constants, dec_bundle_t,
// and arith_op(), the funct3 -> ALU op mapping shared by OP and OP-IMM.
package alu_pkg;

    localparam int XLEN_C = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } dec_bundle_t;

    // alt selects SUB/SRA on the two funct3 codes that have an alternate form
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode_comb.sv
// rtl/alu_ctrl_decode_comb.sv - combinational RV32I instruction to ALU control decode
// Ports: instr (32-bit instruction word) in, bundle (dec_bundle_t) out.
// Illegal encodings yield illegal=1, alu_op=ILLEGAL_OP and every other field zero.
module alu_ctrl_decode_comb
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_OP = 4'd0
) (
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;
    logic        ill;
    dec_bundle_t d;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Shift-immediates carry funct7 in imm[11:5]; the ALU only wants the shamt
    assign imm_sh = {27'b0, instr[24:20]};

    always_comb begin
        d     = '0;
        ill   = 1'b0;
        d.rd  = instr[11:7];
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        case (opc)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    d.alu_op = arith_op(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
                    d.alu_op = arith_op(f3, 1'b1);
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d.alu_src_imm = 1'b1;
                d.rs2         = '0;
                d.imm         = imm_i;
                d.alu_op      = arith_op(f3, 1'b0);
                if (f3 == F3_SLL) begin
                    d.imm = imm_sh;
                    ill   = (f7 != F7_BASE);
                end else if (f3 == F3_SRL_SRA) begin
                    d.imm    = imm_sh;
                    d.alu_op = arith_op(f3, f7 == F7_ALT);
                    ill      = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                d.alu_src_imm = 1'b1;
                d.rs2         = '0;
                d.imm         = imm_i;
            end
            OPC_STORE: begin
                d.alu_src_imm = 1'b1;
                d.rd          = '0;
                d.imm         = imm_s;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.alu_src_imm = 1'b1;
                d.rs1         = '0;
                d.rs2         = '0;
                d.imm         = imm_u;
            end
            OPC_JAL: begin
                d.alu_src_imm = 1'b1;
                d.rs1         = '0;
                d.rs2         = '0;
                d.imm         = imm_j;
            end
            OPC_BRANCH: begin
                d.rd  = '0;
                d.imm = imm_b;
                case (f3)
                    F3_BEQ, F3_BNE:   d.alu_op = ALU_SUB;
                    F3_BLT, F3_BGE:   d.alu_op = ALU_SLT;
                    F3_BLTU, F3_BGEU: d.alu_op = ALU_SLTU;
                    default:          ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            d        = '0;
            d.alu_op = alu_op_e'(ILLEGAL_OP);
        end
        d.illegal = ill;
    end

    assign bundle = d;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - registered RV32I ALU control decode stage with 2-entry skid buffer
// Ports: clk, rst_n (async, active low); in_valid/in_ready/instr input handshake;
// out_valid/out_ready with alu_op, alu_src_imm, imm, rd, rs1, rs2, illegal;
// cnt_decoded/cnt_illegal performance counters.
// Macro ALU_CTRL_DECODER_PERF_CNT_EN enables the counters; otherwise they read 0.
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter logic [3:0] ILLEGAL_OP = 4'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            illegal,
    output logic [31:0]     cnt_decoded,
    output logic [31:0]     cnt_illegal
);

    dec_bundle_t dec;
    dec_bundle_t out_q;
    dec_bundle_t skid_q;
    logic        out_valid_q;
    logic        skid_valid_q;
    logic        accept;
    logic        out_free;

    alu_ctrl_decode_comb #(
        .ILLEGAL_OP (ILLEGAL_OP)
    ) u_decode (
        .instr  (instr),
        .bundle (dec)
    );

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (out_free) begin
            // skid holds the older bundle; while it is full in_ready is low, so no accept competes
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = out_q.alu_op;
    assign alu_src_imm = out_q.alu_src_imm;
    assign imm         = out_q.imm;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign illegal     = out_q.illegal;

`ifdef ALU_CTRL_DECODER_PERF_CNT_EN
    logic [31:0] cnt_dec_q;
    logic [31:0] cnt_ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_dec_q <= '0;
            cnt_ill_q <= '0;
        end else if (out_valid_q && out_ready) begin
            cnt_dec_q <= cnt_dec_q + 32'd1;
            if (out_q.illegal) begin
                cnt_ill_q <= cnt_ill_q + 32'd1;
            end
        end
    end

    assign cnt_decoded = cnt_dec_q;
    assign cnt_illegal = cnt_ill_q;
`else
    assign cnt_decoded = '0;
    assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - self-checking scoreboard bench for alu_ctrl_decoder
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
    logic [31:0] cnt_decoded;
    logic [31:0] cnt_illegal;

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .illegal     (illegal),
        .cnt_decoded (cnt_decoded),
        .cnt_illegal (cnt_illegal)
    );

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
        bit          chk_imm;
        bit          chk_regs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n_ill = 0;

    function automatic exp_t mk(input logic [3:0] op, input logic src, input logic [31:0] im,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic il, input bit ci, input bit cr);
        exp_t e;
        e.op = op; e.src = src; e.imm = im; e.rd = d; e.rs1 = s1; e.rs2 = s2;
        e.ill = il; e.chk_imm = ci; e.chk_regs = cr;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: a transfer happens at the next posedge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed bundle alu_op=%0d with empty scoreboard, expected none", alu_op);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("alu_op", {28'b0, alu_op}, {28'b0, e.op});
                chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
                if (e.chk_imm) chk("imm", imm, e.imm);
                if (e.chk_regs) begin
                    chk("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, e.src});
                    chk("rd", {27'b0, rd}, {27'b0, e.rd});
                    chk("rs1", {27'b0, rs1}, {27'b0, e.rs1});
                    chk("rs2", {27'b0, rs2}, {27'b0, e.rs2});
                end
                n_out++;
                if (e.ill) n_ill++;
            end
        end
    end

    task automatic send(input logic [31:0] i, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        instr    = i;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL accept_timeout: observed no accept for 0x%08h, expected accept within 40 cycles", i);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain_timeout: observed %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        n_out = 0;
        n_ill = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_regs", {17'b0, rd, rs1, rs2}, 32'd0);
        chk("rst_flags", {30'b0, illegal, alu_src_imm}, 32'd0);
        chk("rst_cnt_decoded", cnt_decoded, 32'd0);
        chk("rst_cnt_illegal", cnt_illegal, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD with one-cycle latency
        out_ready = 1'b1;
        send(32'h002081B3, mk(4'd0, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1));
        chk("add_latency", {31'b0, out_valid}, 32'd1);

        // SUB then SRAI back to back, no bubble
        send(32'h407302B3, mk(4'd1, 1'b0, 32'd0, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1));
        send(32'h40315093, mk(4'd7, 1'b1, 32'd3, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1));
        chk("srai_no_bubble_valid", {31'b0, out_valid}, 32'd1);
        chk("srai_no_bubble_op", {28'b0, alu_op}, 32'd7);
        wait_drain();

        // Backpressure: XOR, SLLI accepted, SLTU held off until the skid drains
        out_ready = 1'b0;
        send(32'h0020C1B3, mk(4'd4, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1));
        send(32'h00311093, mk(4'd5, 1'b1, 32'd3, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1));
        in_valid = 1'b1;
        instr    = 32'h0020B1B3;
        @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_op", {28'b0, alu_op}, 32'd4);
        @(negedge clk);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_op2", {28'b0, alu_op}, 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0020B1B3, mk(4'd9, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1));
        wait_drain();

        // Branches, I/S immediates and illegal encodings
        send(32'hFE20ECE3, mk(4'd9, 1'b0, 32'hFFFFFFF8, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1));
        send(32'h0020D863, mk(4'd8, 1'b0, 32'd16, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1));
        send(32'hFFF28213, mk(4'd0, 1'b1, 32'hFFFFFFFF, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1));
        send(32'h0063A623, mk(4'd0, 1'b1, 32'd12, 5'd0, 5'd7, 5'd6, 1'b0, 1'b1, 1'b1));
        send(32'h4020F1B3, mk(4'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0));
        send(32'h02311093, mk(4'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0));
        wait_drain();
`ifdef ALU_CTRL_DECODER_PERF_CNT_EN
        chk("cnt_decoded_run", cnt_decoded, n_out);
        chk("cnt_illegal_run", cnt_illegal, n_ill);
`else
        chk("cnt_decoded_off", cnt_decoded, 32'd0);
        chk("cnt_illegal_off", cnt_illegal, 32'd0);
`endif

        // All-ones word from a fresh reset
        do_reset();
        send(32'hFFFFFFFF, mk(4'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0));
        wait_drain();
`ifdef ALU_CTRL_DECODER_PERF_CNT_EN
        chk("cnt_decoded_ill", cnt_decoded, 32'd1);
        chk("cnt_illegal_ill", cnt_illegal, 32'd1);
`else
        chk("cnt_decoded_ill", cnt_decoded, 32'd0);
        chk("cnt_illegal_ill", cnt_illegal, 32'd0);
`endif

        // Reset while the skid buffer is full
        out_ready = 1'b0;
        send(32'h0020F1B3, mk(4'd2, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1));
        send(32'h0020D1B3, mk(4'd6, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("midrst_no_stale", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
